// File: rtl/uart_frame_rx_pkg.sv
// Shared constants and bit-engine state type for the rsa_rfid UART frame receiver.
package rsa_rfid_pkg;

  localparam int CLKS_PER_BIT = 5208;
  localparam int UART_BITS    = 8;
  localparam int FRAME_BYTES  = 12;
  localparam int FRAME_W      = FRAME_BYTES * UART_BITS;
  localparam int TIMEOUT_BITS = 20;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Frame handoff between the UART frame receiver and the RSA operand loader.
interface uart_frame_rx_if #(
  parameter int FRAME_W = rsa_rfid_pkg::FRAME_W
);

  logic [FRAME_W-1:0] frame_data;
  logic               frame_valid;
  logic               frame_ack;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ack
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ack
  );

endinterface

// File: rtl/uart_frame_rx_byte.sv
// 8N1 byte engine: rx synchroniser plus start/data/stop bit FSM.
module uart_rx_byte
  import rsa_rfid_pkg::*;
#(
  parameter int CLKS_PER_BIT = rsa_rfid_pkg::CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [UART_BITS-1:0] data_byte,
  output logic                 byte_valid,
  output logic                 stop_err,
  output logic                 busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(UART_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_BITS - 1);

  logic                 rx_meta_reg;
  logic                 rx_s_reg;
  rx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic [UART_BITS-1:0] shift_reg, shift_next;
  logic                 rearm_wait_reg, rearm_wait_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_reg    <= 1'b1;
      rx_s_reg       <= 1'b1;
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      rearm_wait_reg <= 1'b0;
    end else begin
      rx_meta_reg    <= rx;
      rx_s_reg       <= rx_meta_reg;
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      rearm_wait_reg <= rearm_wait_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    // After a bad stop bit the line may still be low; wait for it to go high first.
    rearm_wait_next = rearm_wait_reg && !rx_s_reg;
    byte_valid      = 1'b0;
    stop_err        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!rx_s_reg && !rearm_wait_reg) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s_reg ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s_reg, shift_reg[UART_BITS-1:1]};
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == IDX_LAST) begin
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (rx_s_reg) begin
            byte_valid = 1'b1;
          end else begin
            stop_err        = 1'b1;
            rearm_wait_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign data_byte = shift_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: rtl/uart_frame_rx.sv
// Assembles NUM_BYTES UART bytes into one frame word with valid/ack handoff,
// sticky framing/overrun flags and an inter-byte timeout.
module uart_frame_rx
  import rsa_rfid_pkg::*;
#(
  parameter int CLKS_PER_BIT = rsa_rfid_pkg::CLKS_PER_BIT,
  parameter int NUM_BYTES    = FRAME_BYTES,
  parameter int TIMEOUT_BITS = rsa_rfid_pkg::TIMEOUT_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  uart_frame_rx_if.master frame_bus,
  output logic            framing_error,
  output logic            frame_overrun,
  output logic            rx_busy
);

  localparam int FW             = NUM_BYTES * UART_BITS;
  localparam int CNT_W          = $clog2(NUM_BYTES + 1);
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [UART_BITS-1:0] data_byte;
  logic                 byte_valid;
  logic                 stop_err;
  logic                 busy;

  logic [CNT_W-1:0] count_reg;
  logic [FW-1:0]    asm_reg;
  logic [FW-1:0]    asm_next;
  logic [TMO_W-1:0] tmo_reg;
  logic [FW-1:0]    frame_data_reg;
  logic             frame_valid_reg;
  logic             framing_error_reg;
  logic             frame_overrun_reg;
  logic             frame_done;
  logic             tmo_expired;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_byte (data_byte),
    .byte_valid(byte_valid),
    .stop_err  (stop_err),
    .busy      (busy)
  );

  // asm_next already contains the incoming byte so the final byte lands in frame_data directly.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_slot
    assign asm_next[gi*UART_BITS +: UART_BITS] =
      (byte_valid && count_reg == CNT_W'(gi)) ? data_byte : asm_reg[gi*UART_BITS +: UART_BITS];
  end

  assign frame_done  = byte_valid && (count_reg == LAST_BYTE);
  assign tmo_expired = !busy && (count_reg != '0) && (tmo_reg == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg         <= '0;
      asm_reg           <= '0;
      tmo_reg           <= '0;
      frame_data_reg    <= '0;
      frame_valid_reg   <= 1'b0;
      framing_error_reg <= 1'b0;
      frame_overrun_reg <= 1'b0;
    end else begin
      asm_reg <= asm_next;

      if (stop_err || frame_done || tmo_expired) begin
        count_reg <= '0;
      end else if (byte_valid) begin
        count_reg <= count_reg + 1'b1;
      end

      if (busy || count_reg == '0 || tmo_expired) begin
        tmo_reg <= '0;
      end else begin
        tmo_reg <= tmo_reg + 1'b1;
      end

      // A same-cycle ack counts as consumption of the old frame, so no overrun.
      if (frame_done) begin
        frame_data_reg  <= asm_next;
        frame_valid_reg <= 1'b1;
        if (frame_valid_reg && !frame_bus.frame_ack) begin
          frame_overrun_reg <= 1'b1;
        end
      end else if (frame_bus.frame_ack) begin
        frame_valid_reg <= 1'b0;
      end

      if (stop_err) begin
        framing_error_reg <= 1'b1;
      end
    end
  end

  assign frame_bus.frame_data  = frame_data_reg;
  assign frame_bus.frame_valid = frame_valid_reg;
  assign framing_error         = framing_error_reg;
  assign frame_overrun         = frame_overrun_reg;
  assign rx_busy               = busy;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed table, reset/collision sequences, randomized ops vs a byte-level model.
module tb_uart_frame_rx;

  localparam int CPB      = 16;
  localparam int NB       = 12;
  localparam int TMO_BITS = 20;
  localparam int FW       = NB * 8;

  typedef enum int {OP_RESET, OP_FRAME1, OP_FRAME2, OP_ACK, OP_GLITCH, OP_BADBYTE, OP_PART5} op_e;

  typedef struct {
    op_e           op;
    logic          exp_valid;
    logic          exp_ferr;
    logic          exp_ovr;
    logic [FW-1:0] exp_data;
    int            exp_rises;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic framing_error, frame_overrun, rx_busy;
  logic ack_on_bv = 1'b0;
  logic fv_prev = 1'b0;
  logic bv_prev = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rises = 0;

  logic [FW-1:0] f1;
  logic [FW-1:0] f2;
  vec_t          vec [15];

  uart_frame_rx_if #(.FRAME_W(FW)) bus ();

  uart_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .NUM_BYTES   (NB),
    .TIMEOUT_BITS(TMO_BITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .frame_bus    (bus.master),
    .framing_error(framing_error),
    .frame_overrun(frame_overrun),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // frame_valid must rise the cycle right after the final byte's byte_valid.
  always @(negedge clk) begin
    if (reset && bus.frame_valid && !fv_prev) begin
      rises <= rises + 1;
      check1("latency", bv_prev, 1'b1);
    end
    fv_prev <= bus.frame_valid;
    bv_prev <= dut.byte_valid;
  end

  task automatic send_bit(input logic v);
    rx = v;
    for (int c = 0; c < CPB; c++) begin
      if (ack_on_bv) bus.frame_ack = dut.byte_valid;
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input logic collide);
    for (int k = 0; k < NB; k++) begin
      ack_on_bv = collide && (k == NB - 1);
      send_byte(f[k*8 +: 8], 1'b1);
    end
    ack_on_bv     = 1'b0;
    bus.frame_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    repeat (len) @(negedge clk);
    idle(2);
  endtask

  task automatic check_state(input string tag, input logic ev, input logic [FW-1:0] ed,
                             input logic ee, input logic eo);
    check1({tag, "_valid"}, bus.frame_valid, ev);
    checkw({tag, "_data"}, bus.frame_data, ed);
    check1({tag, "_ferr"}, framing_error, ee);
    check1({tag, "_ovr"}, frame_overrun, eo);
    check1({tag, "_busy"}, rx_busy, 1'b0);
  endtask

  // Byte-level reference model for the random phase.
  logic [7:0]    part [$];
  logic          m_valid, m_ferr, m_ovr;
  logic [FW-1:0] m_data;
  int            idle_bits;

  task automatic model_byte(input logic [7:0] b);
    part.push_back(b);
    if (part.size() == NB) begin
      m_data = '0;
      for (int k = 0; k < NB; k++) m_data[k*8 +: 8] = part[k];
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      part.delete();
    end
  endtask

  initial begin
    int r0;
    reset         = 1'b0;
    rx            = 1'b1;
    bus.frame_ack = 1'b0;
    f1 = 96'h5691BA33571A82314C19A1E5;
    f2 = 96'h000000000000000000000001;

    vec[0]  = '{OP_RESET,   1'b0, 1'b0, 1'b0, '0, 0};
    vec[1]  = '{OP_FRAME1,  1'b1, 1'b0, 1'b0, f1, 1};
    vec[2]  = '{OP_ACK,     1'b0, 1'b0, 1'b0, f1, 0};
    vec[3]  = '{OP_ACK,     1'b0, 1'b0, 1'b0, f1, 0};
    vec[4]  = '{OP_GLITCH,  1'b0, 1'b0, 1'b0, f1, 0};
    vec[5]  = '{OP_FRAME1,  1'b1, 1'b0, 1'b0, f1, 1};
    vec[6]  = '{OP_ACK,     1'b0, 1'b0, 1'b0, f1, 0};
    vec[7]  = '{OP_BADBYTE, 1'b0, 1'b1, 1'b0, f1, 0};
    vec[8]  = '{OP_FRAME1,  1'b1, 1'b1, 1'b0, f1, 1};
    vec[9]  = '{OP_ACK,     1'b0, 1'b1, 1'b0, f1, 0};
    vec[10] = '{OP_PART5,   1'b0, 1'b1, 1'b0, f1, 0};
    vec[11] = '{OP_FRAME1,  1'b1, 1'b1, 1'b0, f1, 1};
    vec[12] = '{OP_ACK,     1'b0, 1'b1, 1'b0, f1, 0};
    vec[13] = '{OP_FRAME1,  1'b1, 1'b1, 1'b0, f1, 1};
    vec[14] = '{OP_FRAME2,  1'b1, 1'b1, 1'b1, f2, 0};

    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      r0 = rises;
      case (vec[i].op)
        OP_RESET: begin
          reset = 1'b0;
          repeat (3) @(negedge clk);
          reset = 1'b1;
          idle(2);
        end
        OP_FRAME1:  send_frame(f1, 1'b0);
        OP_FRAME2:  send_frame(f2, 1'b0);
        OP_ACK:     pulse_ack();
        OP_GLITCH:  glitch(5);
        OP_BADBYTE: begin
          send_byte(8'h55, 1'b0);
          idle(2);
        end
        OP_PART5: begin
          for (int k = 0; k < 5; k++) send_byte(8'hC3, 1'b1);
          idle(25);
        end
        default: ;
      endcase
      check_state($sformatf("row%0d", i), vec[i].exp_valid, vec[i].exp_data,
                  vec[i].exp_ferr, vec[i].exp_ovr);
      checki($sformatf("row%0d_rises", i), rises - r0, vec[i].exp_rises);
      $display("row %0d op %0d: valid=%b data=%h ferr=%b ovr=%b", i, vec[i].op,
               bus.frame_valid, bus.frame_data, framing_error, frame_overrun);
    end

    // Reset in the middle of byte 6, then a clean frame.
    for (int k = 0; k < 5; k++) send_byte(f1[k*8 +: 8], 1'b1);
    send_bit(1'b0);
    send_bit(f1[40]);
    send_bit(f1[41]);
    check1("busy_mid", rx_busy, 1'b1);
    reset = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    check_state("in_reset", 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(2);
    send_frame(f1, 1'b0);
    check_state("post_reset", 1'b1, f1, 1'b0, 1'b0);
    $display("reset seq: valid=%b data=%h ferr=%b ovr=%b", bus.frame_valid, bus.frame_data,
             framing_error, frame_overrun);

    // Ack coincides with completion of the next frame.
    r0 = rises;
    send_frame(f2, 1'b1);
    check_state("collide", 1'b1, f2, 1'b0, 1'b0);
    checki("collide_rises", rises - r0, 0);
    pulse_ack();
    check_state("collide_ack", 1'b0, f2, 1'b0, 1'b0);
    $display("collision seq: valid=%b data=%h ovr=%b", bus.frame_valid, bus.frame_data,
             frame_overrun);

    m_valid   = 1'b0;
    m_ferr    = 1'b0;
    m_ovr     = 1'b0;
    m_data    = f2;
    idle_bits = 0;
    for (int n = 0; n < 120; n++) begin
      int         r;
      int         gap;
      logic [7:0] b;
      r = int'($urandom_range(99));
      b = 8'($urandom);
      if (r < 12) begin
        pulse_ack();
        m_valid = 1'b0;
      end else begin
        gap = ($urandom_range(99) < 4) ? 25 : int'($urandom_range(2));
        idle(gap);
        idle_bits += gap;
        if (idle_bits >= TMO_BITS) part.delete();
        if (r < 15) begin
          glitch(int'($urandom_range(1, 5)));
          idle_bits = 2;
        end else if (r < 18) begin
          send_byte(b, 1'b0);
          idle(1);
          m_ferr = 1'b1;
          part.delete();
          idle_bits = 1;
        end else begin
          send_byte(b, 1'b1);
          idle_bits = 0;
          model_byte(b);
        end
      end
      check_state($sformatf("rnd%0d", n), m_valid, m_data, m_ferr, m_ovr);
      $display("rnd %0d r=%0d byte=%h part=%0d valid=%b ferr=%b ovr=%b", n, r, b, part.size(),
               bus.frame_valid, framing_error, frame_overrun);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Serial front end for rsa_rfid. Receives 8N1 UART bytes on rx and assembles NUM_BYTES bytes into one flat frame word that feeds the RSA datapath operand registers. Presents the frame with a level valid/ack handshake, and flags framing errors and overruns. Sits directly upstream of the RSA core, between the board rx pin and the core's operand load.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud)
NUM_BYTES, 12, bytes per frame
TIMEOUT_BITS, 20, idle bit-times after which a partial frame is discarded

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset
rx  input  1  UART serial input, idle high, asynchronous to clk
frame_ack  input  1  consumer has taken frame_data; clears frame_valid
frame_data  output  NUM_BYTES*8  assembled frame; first received byte is in bits [7:0]
frame_valid  output  1  high from frame completion until acked
framing_error  output  1  sticky; stop bit sampled low
frame_overrun  output  1  sticky; new frame completed while frame_valid was still high
rx_busy  output  1  high while the bit engine is outside IDLE

Behaviour:
- Reset (reset=0, async):
  - frame_data=0, frame_valid=0, framing_error=0, frame_overrun=0, rx_busy=0.
  - Byte count=0, bit FSM=IDLE.
  - Both rx synchroniser flops preset to 1.
- Synchroniser: rx passes through a 2-flop synchroniser. All decisions use the synchronised value rx_s.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s=0 -> START, counter cleared.
  - START: at count CLKS_PER_BIT/2-1, re-sample rx_s. If 0 -> DATA, counter cleared. If 1 -> IDLE (glitch rejected, no byte, no error).
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register. After the 8th sample -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1: emit byte_valid for 1 cycle, -> IDLE.
    - 0: set framing_error, discard the byte, reset byte count to 0, -> IDLE. IDLE re-arms only after rx_s has returned to 1.
- Frame assembly:
  - On byte_valid, the byte goes into byte slot [count*8 +: 8] of an internal assembly register, and count increments.
  - When count reaches NUM_BYTES-1 and byte_valid fires: on the next clk edge, frame_data <= assembly register (including this byte), frame_valid <= 1, count <= 0.
- Latency: frame_valid rises exactly 1 cycle after the last byte's byte_valid.
- Handshake:
  - frame_ack while frame_valid=1: frame_valid clears next cycle.
  - frame_ack while frame_valid=0: ignored.
  - frame_data holds its value until the next frame completes.
- Overrun: a frame completes while frame_valid=1 and frame_ack is not asserted that same cycle -> frame_data is overwritten, frame_valid stays 1, frame_overrun is set.
- Ack/completion collision: frame_ack and frame completion in the same cycle -> frame_valid stays 1, new data is loaded, no overrun.
- Inter-byte timeout: count>0 and FSM in IDLE for TIMEOUT_BITS*CLKS_PER_BIT consecutive cycles -> count <= 0, partial frame discarded, no flag.
- Sticky flags: framing_error and frame_overrun clear only on reset.
- Reset mid-byte or mid-frame: all state is abandoned. The next falling edge after reset release starts a fresh byte 0.
- Counter widths: the bit counter is sized as clog2(CLKS_PER_BIT). The timeout counter is sized for TIMEOUT_BITS*CLKS_PER_BIT.

Decomposition:
- Shared package rsa_rfid_pkg holds:
  - CLKS_PER_BIT default, UART_BITS=8, FRAME_BYTES=12, FRAME_W=96.
  - The bit-FSM state enum (IDLE, START, DATA, STOP).
- One sub-module, uart_rx_byte: synchroniser plus bit FSM, outputting byte, byte_valid, stop_err and busy.
- The top level holds the byte counter, assembly register, timeout counter, handshake and flags.

Test Plan:
1. Reset released, 12 bytes E5,A1,19,4C,31,82,1A,57,33,BA,91,56 at 104166 ns/bit, back-to-back -> frame_valid=1, frame_data=96'h5691BA33571A82314C19A1E5. frame_ack pulse -> frame_valid=0 next cycle, frame_data unchanged.
2. rx low for 1000 cycles (< CLKS_PER_BIT/2) then high, followed by frame 1 -> glitch produces no byte, frame_data identical to scenario 1, framing_error=0.
3. Byte 0x55 sent with stop bit 0, then rx high, then full frame 1 -> framing_error=1, and frame_data equals frame 1 (the partial is not merged).
4. 5 bytes, rx idle 25 bit-times, then full frame 1 -> single frame_valid, frame_data equals frame 1.
5. Frame 1 then frame 2 (all bytes 0x00 except the first, 0x01) without ack -> frame_overrun=1, frame_valid=1, frame_data=96'h000000000000000000000001.
6. Assert reset during byte 6 of a frame, release, send full frame 1 -> all outputs 0 during reset, then frame_data equals frame 1 with no error flags.
